regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W: default 32; data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W: default 5; address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG: default 0; when 1, register 0 always reads 0 and writes to it are dropped.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 write  in  1  write strobe.
REQ-007 wrAddr  in  ADDR_W  write address.
REQ-008 wrData  in  DATA_W  write data.
REQ-009 wrBe  in  DATA_W/8  byte enables, bit i covers wrData[8i+7:8i].
REQ-010 rdAddrA / rdAddrB  in  ADDR_W  read addresses, ports A and B.
REQ-011 rdDataA / rdDataB  out  DATA_W  registered read data.
REQ-012 rdValidA / rdValidB  out  1  addressed register written since last reset/clear.
REQ-013 clear  in  1  request to zero the whole file.
REQ-014 busy  out  1  clear sequence in progress.

Function
REQ-015 Read latency is 1 cycle: rdDataX/rdValidX at edge N+1 reflect rdAddrX sampled at edge N.
REQ-016 Each register has a valid bit; a register whose valid bit is 0 SHALL read as 0 with rdValidX=0, whatever its storage holds.
REQ-017 A write is accepted when write=1, wrBe!=0, busy=0, clear=0, and not (ZERO_REG=1 and wrAddr=0).
REQ-018 Accepted write: enabled bytes take wrData; disabled bytes keep old data if valid, else become 0; valid bit set to 1.
REQ-019 Bypass: if an accepted write and a read hit the same address in the same cycle, the read returns the merged new value with rdValid=1; both ports bypass independently.
REQ-020 write=1 with wrBe=0 is a no-op.
REQ-021 FSM states: IDLE, CLEAR.
REQ-022 IDLE -> CLEAR when clear=1; the write in the same cycle is dropped; busy rises on the next edge.
REQ-023 CLEAR: one address per cycle, ascending 0 to DEPTH-1; zero the storage and the valid bit; busy=1 for exactly DEPTH cycles.
REQ-024 CLEAR -> IDLE after address DEPTH-1 is cleared; a write is accepted in the first cycle busy=0.
REQ-025 During CLEAR: clear is ignored (no restart); writes are dropped; reads continue normally, with masking per REQ-016.
REQ-026 The clear address counter wraps to 0 on exit; width is exactly ADDR_W.
REQ-027 ZERO_REG=1: reads of address 0 return 0 with rdValid=1 at all times after reset.

Reset
REQ-028 reset=0 at a rising edge SHALL clear all valid bits, set rdDataA/B=0, rdValidA/B=0, busy=0, FSM=IDLE, and clear counter=0.
REQ-029 Storage array is not reset; REQ-016 masking makes it unobservable.
REQ-030 Reset during CLEAR aborts the sequence immediately; the next cycle is IDLE with all valid bits 0.
REQ-031 Reset overrides write and clear in the same cycle.

Structure
REQ-032 The shared package regfile_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the byte-lane constant 8.
REQ-033 The sub-module regfile_be_merge (combinational byte-enable merge of old data, new data and valid) SHALL be used for both the storage write and the bypass path.
REQ-034 Storage is one array of DEPTH x DATA_W with a DEPTH-bit valid vector; the target is 120-400 lines of RTL.

Verification
REQ-035 Reset, then read A=6, B=4 -> rdDataA=rdDataB=0 and rdValidA=rdValidB=0 one cycle later.
REQ-036 Write addr 1 = 0xABCDEFAB with wrBe=0xF, then read B=1 -> 0xABCDEFAB with rdValidB=1; a following write of 0x01234567 with wrBe=0x3 -> reads 0xABCD4567.
REQ-037 Same cycle: write addr 8 = 0x11223344 with wrBe=0xF, rdAddrA=8 -> next cycle rdDataA=0x11223344 (bypass); a partial write to an invalid register with wrBe=0x1, data 0xFFFFFFFF -> reads 0x000000FF.
REQ-038 Fill all 32 registers, pulse clear with a simultaneous write to addr 3 -> busy high for exactly 32 cycles, all reads 0/invalid afterwards, and the addr-3 write is lost.
REQ-039 Pulse clear, then drop reset after 10 cycles -> busy=0 on the next edge; a write is accepted on the following cycle.
REQ-040 ZERO_REG=1: write 0xDEADBEEF to addr 0 -> rdDataA=0 with rdValidA=1; repeat with DATA_W=64, ADDR_W=3 and check the byte merge across 8 lanes.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants
// for the parameterised register file.
package regfile_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rfState_t;

endpackage

// File: rtl/regfile_be_merge.sv
// regfile_be_merge: byte-enable merge of new
// write data over the old register contents.
module regfile_be_merge
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]        oldData,
  input  logic [DATA_W-1:0]        newData,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic                     oldValid,
  output logic [DATA_W-1:0]        merged
);

  localparam int NB = DATA_W / BYTE_W;

  // Per lane: new byte, kept byte, or zero for a never-written register.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NB; i++) begin
      if (be[i])
        merged[i*BYTE_W +: BYTE_W] = newData[i*BYTE_W +: BYTE_W];
      else if (oldValid)
        merged[i*BYTE_W +: BYTE_W] = oldData[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with
// byte enables, valid bits, bypass and sequential clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic [DATA_W/BYTE_W-1:0] wrBe,
  input  logic [ADDR_W-1:0]        rdAddrA,
  input  logic [ADDR_W-1:0]        rdAddrB,
  output logic [DATA_W-1:0]        rdDataA,
  output logic [DATA_W-1:0]        rdDataB,
  output logic                     rdValidA,
  output logic                     rdValidB,
  input  logic                     clear,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  rfState_t          state;
  rfState_t          stateNext;
  logic [ADDR_W-1:0] clrAddr;
  logic              clrEn;
  logic              zeroWr;
  logic              wrAcc;
  logic [DATA_W-1:0] merged;
  logic [DATA_W:0]   nextA;
  logic [DATA_W:0]   nextB;

  assign zeroWr = (ZERO_REG != 0) && (wrAddr == '0);
  assign wrAcc  = write && (wrBe != '0) && !busy
               && !clear && !zeroWr;

  // One merge feeds both the storage write and the read bypass.
  regfile_be_merge #(
    .DATA_W (DATA_W)
  ) uMerge (
    .oldData  (mem[wrAddr]),
    .newData  (wrData),
    .be       (wrBe),
    .oldValid (valid[wrAddr]),
    .merged   (merged)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM next state: enter on clear, leave after the last address.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (clear) stateNext = CLEAR;
      CLEAR: if (clrAddr == LAST) stateNext = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy  = 1'b0;
    clrEn = 1'b0;
    unique case (state)
      IDLE:  ;
      CLEAR: begin
        busy  = 1'b1;
        clrEn = 1'b1;
      end
    endcase
  end

  // Clear address counter; wraps back to 0 on the last address.
  always_ff @(posedge clk) begin
    if (!reset)     clrAddr <= '0;
    else if (clrEn) clrAddr <= clrAddr + 1'b1;
  end

  // Storage array, not reset: valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (clrEn)      mem[clrAddr] <= '0;
    else if (wrAcc) mem[wrAddr]  <= merged;
  end

  // Valid bits: dropped by reset or clear, set by an accepted write.
  always_ff @(posedge clk) begin
    if (!reset)     valid          <= '0;
    else if (clrEn) valid[clrAddr] <= 1'b0;
    else if (wrAcc) valid[wrAddr]  <= 1'b1;
  end

  function automatic logic [DATA_W:0] readPort(
    input logic [ADDR_W-1:0] a
  );
    if ((ZERO_REG != 0) && (a == '0))
      return {1'b1, {DATA_W{1'b0}}};
    if (wrAcc && (a == wrAddr))
      return {1'b1, merged};
    if (valid[a])
      return {1'b1, mem[a]};
    return '0;
  endfunction

  // Read lookup with bypass and invalid masking.
  always_comb begin
    nextA = readPort(rdAddrA);
    nextB = readPort(rdAddrB);
  end

  // Registered read outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdDataA  <= '0;
      rdDataB  <= '0;
      rdValidA <= 1'b0;
      rdValidB <= 1'b0;
    end else begin
      {rdValidA, rdDataA} <= nextA;
      {rdValidB, rdDataB} <= nextB;
    end
  end

endmodule
